// File: rtl/shift_tx_ctrl_if.sv
// Handshake and serial-output bundle for shift_tx_ctrl.
// The master drives words and control; the slave serializes.
interface shift_tx_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             msb_first;
    logic             hold;
    logic             sout;
    logic             sout_en;
    logic             sof;
    logic             eof;
    logic             busy;

    modport master (
        output din, din_valid, msb_first, hold,
        input  din_ready, sout, sout_en, sof, eof, busy
    );

    modport slave (
        input  din, din_valid, msb_first, hold,
        output din_ready, sout, sout_en, sof, eof, busy
    );
endinterface

// File: rtl/shift_tx_ctrl.sv
// Parallel-in/serial-out sequencer: accepts a word over valid/ready and shifts it out
// one bit per clock, MSB- or LSB-first, with frame strobes, stall and gapless streaming.
module shift_tx_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input logic          clk,
    input logic          reset_,
    shift_tx_ctrl_if.slave tx
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [CW-1:0]    cnt_q;
    logic             ord_q;

    logic in_shift;
    logic at_last;
    logic cnt_bad;
    logic ready;
    logic accept;
    logic sout_en;

    assign in_shift = (state_q == StShift);
    assign at_last  = (cnt_q == LAST);
    assign cnt_bad  = (cnt_q > LAST);
    // Ready on the final unstalled bit so the next word follows with no gap.
    assign ready    = !in_shift || (at_last && !tx.hold);
    assign accept   = tx.din_valid && ready;
    assign sout_en  = in_shift && !tx.hold;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            cnt_q   <= '0;
            ord_q   <= 1'b1;
        end else if (accept) begin
            state_q <= StShift;
            sreg_q  <= tx.din;
            cnt_q   <= '0;
            ord_q   <= tx.msb_first;
        end else if (in_shift) begin
            if (cnt_bad) begin
                // Unreachable count: recover to idle rather than run on.
                state_q <= StIdle;
                cnt_q   <= '0;
            end else if (!tx.hold) begin
                sreg_q <= ord_q ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
                if (at_last) begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign tx.din_ready = ready;
    assign tx.sout      = in_shift && (ord_q ? sreg_q[WIDTH-1] : sreg_q[0]);
    assign tx.sout_en   = sout_en;
    assign tx.sof       = sout_en && (cnt_q == '0);
    assign tx.eof       = sout_en && at_last;
    assign tx.busy      = in_shift;
endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Scoreboard bench for shift_tx_ctrl: accepted words expand into a queue of expected
// serial bits; a monitor checks outputs each cycle against the queue front.
module tb_shift_tx_ctrl;
    localparam int unsigned W = 4;

    typedef struct packed {
        logic b;
        logic sof;
        logic eof;
    } exp_t;

    logic clk = 1'b0;
    logic reset_ = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    shift_tx_ctrl_if #(.WIDTH(W)) bus ();

    shift_tx_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset_ (reset_),
        .tx     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples 1 ns before each rising edge.
    always @(negedge clk) begin : monitor
        logic e_busy, e_en, e_ready;
        #4;
        if (!reset_) begin
            chk("rst_sout", bus.sout, 0);
            chk("rst_en", bus.sout_en, 0);
            chk("rst_sof", bus.sof, 0);
            chk("rst_eof", bus.eof, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_ready", bus.din_ready, 1);
            q.delete();
        end else begin
            e_busy  = (q.size() != 0);
            e_en    = e_busy && !bus.hold;
            e_ready = (q.size() == 0) || (q.size() == 1 && !bus.hold);
            chk("busy", bus.busy, e_busy);
            chk("sout_en", bus.sout_en, e_en);
            chk("din_ready", bus.din_ready, e_ready);
            if (e_busy) chk("sout", bus.sout, q[0].b);
            else        chk("idle_sout", bus.sout, 0);
            if (e_en) begin
                chk("sof", bus.sof, q[0].sof);
                chk("eof", bus.eof, q[0].eof);
                void'(q.pop_front());
            end else begin
                chk("sof_off", bus.sof, 0);
                chk("eof_off", bus.eof, 0);
            end
        end
    end

    // One clock of stimulus, entered and left at a falling edge.
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic m, input logic h,
                       output logic acc);
        bus.din_valid = v;
        bus.din       = d;
        bus.msb_first = m;
        bus.hold      = h;
        acc = reset_ && v && ((q.size() == 0) || (q.size() == 1 && !h));
        @(posedge clk);
        #1;
        if (acc) begin
            for (int i = 0; i < int'(W); i++) begin
                exp_t e;
                e.b   = m ? d[W-1-i] : d[i];
                e.sof = (i == 0);
                e.eof = (i == int'(W) - 1);
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic h);
        logic a;
        repeat (n) cyc(1'b0, '0, 1'b0, h, a);
    endtask

    task automatic send(input logic [W-1:0] d, input logic m, input logic h);
        logic a = 1'b0;
        int   n = 0;
        while (!a && n < 20) begin
            cyc(1'b1, d, m, h, a);
            n++;
        end
        if (!a) chk("accept_timeout", 0, 1);
    endtask

    initial begin
        logic a;
        bus.din_valid = 1'b0;
        bus.din       = '0;
        bus.msb_first = 1'b0;
        bus.hold      = 1'b0;
        repeat (3) @(negedge clk);
        reset_ = 1'b1;
        @(negedge clk);

        // MSB-first single word, then LSB-first with msb_first toggled mid-frame.
        send(4'b1011, 1'b1, 1'b0);
        idle(6, 1'b0);
        send(4'b1011, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, a);
        cyc(1'b0, '0, 1'b1, 1'b0, a);
        idle(4, 1'b0);

        // Back-to-back streaming.
        send(4'hA, 1'b1, 1'b0);
        send(4'h5, 1'b1, 1'b0);
        idle(6, 1'b0);

        // Two hold cycles at bit 1.
        send(4'b1100, 1'b1, 1'b0);
        idle(1, 1'b0);
        idle(2, 1'b1);
        idle(5, 1'b0);

        // Hold on the eof cycle with a word waiting.
        send(4'b1001, 1'b1, 1'b0);
        idle(3, 1'b0);
        cyc(1'b1, 4'h3, 1'b1, 1'b1, a);
        send(4'h3, 1'b1, 1'b0);
        idle(6, 1'b0);

        // Asynchronous reset mid-frame at bit 2.
        send(4'b1011, 1'b1, 1'b0);
        idle(2, 1'b0);
        #2 reset_ = 1'b0;
        #1;
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_en", bus.sout_en, 0);
        chk("async_rst_eof", bus.eof, 0);
        chk("async_rst_sout", bus.sout, 0);
        @(negedge clk);
        @(negedge clk);
        reset_ = 1'b1;
        send(4'b0110, 1'b1, 1'b0);
        idle(6, 1'b0);

        // Hold while idle: accepted, first bit waits for hold to drop.
        send(4'b1101, 1'b0, 1'b1);
        idle(2, 1'b1);
        idle(6, 1'b0);

        // Random traffic.
        repeat (400) begin
            cyc(($urandom_range(0, 9) < 7), W'($urandom), 1'($urandom),
                ($urandom_range(0, 4) == 0), a);
        end

        for (int n = 0; n < 40 && q.size() != 0; n++) idle(1, 1'b0);
        idle(2, 1'b0);
        chk("drain_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
